// File: rtl/hello_pkg.sv
// Shared constants for the "Hello" stream arbiter: ASCII bytes, matcher and arbiter state encodings.
package hello_pkg;

  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_e = 8'h65;
  localparam logic [7:0] CH_l = 8'h6C;
  localparam logic [7:0] CH_o = 8'h6F;

  typedef enum logic [4:0] {
    CHECK_H  = 5'b00001,
    CHECK_e  = 5'b00010,
    CHECK_l1 = 5'b00100,
    CHECK_l2 = 5'b01000,
    CHECK_o  = 5'b10000
  } match_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/hello_matcher.sv
// Case-sensitive "Hello" detector; advances only on accepted bytes, registered hit pulse.
//  state    | meaning
//  CHECK_H  | waiting for 'H'
//  CHECK_e  | seen "H"
//  CHECK_l1 | seen "He"
//  CHECK_l2 | seen "Hel"
//  CHECK_o  | seen "Hell"
module hello_matcher
  import hello_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       vld,
  input  logic [7:0] data,
  output logic       hit
);

  match_state_t state, state_nxt, miss_state;
  logic         hit_nxt;

  always_comb begin
    state_nxt  = state;
    hit_nxt    = 1'b0;
    // A stray 'H' is also the start of a new candidate word.
    miss_state = (data == CH_H) ? CHECK_e : CHECK_H;
    if (clr) begin
      state_nxt = CHECK_H;
    end else if (vld) begin
      case (state)
        CHECK_H:  state_nxt = (data == CH_H) ? CHECK_e  : CHECK_H;
        CHECK_e:  state_nxt = (data == CH_e) ? CHECK_l1 : miss_state;
        CHECK_l1: state_nxt = (data == CH_l) ? CHECK_l2 : miss_state;
        CHECK_l2: state_nxt = (data == CH_l) ? CHECK_o  : miss_state;
        CHECK_o: begin
          if (data == CH_o) begin
            state_nxt = CHECK_H;
            hit_nxt   = 1'b1;
          end else begin
            state_nxt = miss_state;
          end
        end
        default:  state_nxt = CHECK_H;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CHECK_H;
      hit   <= 1'b0;
    end else begin
      state <= state_nxt;
      hit   <= hit_nxt;
    end
  end

endmodule

// File: rtl/hello_stream_arbiter.sv
// Round-robin, frame-granular arbiter sharing one "Hello" matcher among NCH byte streams.
//  state     | meaning
//  ARB_IDLE  | no owner; scanning requests from rr+1
//  ARB_BUSY  | grant_id owns the matcher until req_last or timeout
//  ARB_ABORT | one-cycle stalled-frame drop
module hello_stream_arbiter
  import hello_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255,
  parameter int TOW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req_valid,
  input  logic [8*NCH-1:0] req_data,
  input  logic [NCH-1:0]   req_last,
  output logic [NCH-1:0]   req_ready,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic             hit,
  output logic [IDW-1:0]   hit_id,
  output logic             abort,
  output logic [NCH-1:0]   led
);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] grant_nxt, rr, rr_nxt, sel, cand;
  logic [TOW-1:0] cnt, cnt_nxt;
  logic [NCH-1:0] led_q, hit_mask;
  logic [7:0]     chan_data [NCH];
  logic           found, hs;

  for (genvar g = 0; g < NCH; g++) begin : g_data
    assign chan_data[g] = req_data[8*g+7 -: 8];
  end

  assign hs    = (state == ARB_BUSY) && req_valid[grant_id];
  assign busy  = (state == ARB_BUSY);
  assign abort = (state == ARB_ABORT);

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = IDW'((int'(rr) + 1 + i) % NCH);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    case (state)
      ARB_IDLE: begin
        cnt_nxt = '0;
        if (found) begin
          grant_nxt = sel;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (hs) begin
          cnt_nxt = '0;
          if (req_last[grant_id]) begin
            state_nxt = ARB_IDLE;
            rr_nxt    = grant_id;
          end
        end else begin
          cnt_nxt = cnt + TOW'(1);
          if (cnt_nxt == TOW'(TIMEOUT)) state_nxt = ARB_ABORT;
        end
      end
      ARB_ABORT: begin
        cnt_nxt   = '0;
        rr_nxt    = grant_id;
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == ARB_BUSY) req_ready[grant_id] = 1'b1;
  end

  // LED output already reflects the toggle while hit is high; led_q catches up a cycle later.
  always_comb begin
    hit_mask         = '0;
    hit_mask[hit_id] = hit;
  end
  assign led = led_q ^ hit_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      grant_id <= '0;
      rr       <= '0;
      cnt      <= '0;
      hit_id   <= '0;
      led_q    <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr       <= rr_nxt;
      cnt      <= cnt_nxt;
      led_q    <= led_q ^ hit_mask;
      if (hs) hit_id <= grant_id;
    end
  end

  hello_matcher u_matcher (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != ARB_BUSY),
    .vld  (hs),
    .data (chan_data[grant_id]),
    .hit  (hit)
  );

endmodule
